// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline controller for the 5-stage MIPS core: stall/flush generation,
// exception sequencing, mul/div interlock and stall/flush statistics.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken_id,
  input  logic        md_start_ex,
  input  logic        id_uses_hilo,
  input  logic        id_is_md,
  input  logic        imem_ready,
  input  logic        exc_req_ex,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        epc_we,
  output logic        pc_sel_exc,
  output logic        md_busy,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic {RUN, EXC_VEC} state_t;

  state_t     state;
  logic [7:0] md_cnt;
  logic       md_active;
  logic       load_use;
  logic       md_stall;
  logic       hazard;

  assign md_active = (md_cnt != '0);
  assign md_busy   = md_active & ~reset;

  assign load_use = ex_memread && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign md_stall = md_active && (id_uses_hilo || id_is_md);
  assign hazard   = load_use || md_stall;

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_flush     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    epc_we       = 1'b0;
    pc_sel_exc   = 1'b0;
    if (!reset) begin
      unique case (state)
        EXC_VEC: begin
          pc_sel_exc = 1'b1;
          pc_write   = 1'b1;
          if_flush   = 1'b1;
        end
        default: begin
          if (exc_req_ex) begin
            if_flush     = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            epc_we       = 1'b1;
          end else if (hazard) begin
            // Branch is ignored here: its operands in ID are stale.
            id_ex_flush = 1'b1;
          end else if (branch_taken_id) begin
            pc_write = 1'b1;
            if_flush = 1'b1;
          end else if (!imem_ready) begin
            if_flush = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      md_cnt    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      unique case (state)
        EXC_VEC: begin
          state <= RUN;
          if (md_active) md_cnt <= md_cnt - 8'd1;
        end
        default: begin
          if (exc_req_ex) begin
            state  <= EXC_VEC;
            md_cnt <= '0;
          end else if (md_start_ex) begin
            md_cnt <= 8'(MD_CYCLES);
          end else if (md_active) begin
            md_cnt <= md_cnt - 8'd1;
          end
        end
      endcase
      if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (if_flush && (flush_cnt != '1))  flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic, all
// compared against a behavioural model of the controller rules.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_memread, branch_taken_id, md_start_ex;
  logic        id_uses_hilo, id_is_md, imem_ready, exc_req_ex;
  logic        pc_write, if_id_write, if_flush, id_ex_flush, ex_mem_flush;
  logic        epc_we, pc_sel_exc, md_busy;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.MD_CYCLES(MD)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .branch_taken_id(branch_taken_id), .md_start_ex(md_start_ex),
    .id_uses_hilo(id_uses_hilo), .id_is_md(id_is_md),
    .imem_ready(imem_ready), .exc_req_ex(exc_req_ex),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_flush(if_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .epc_we(epc_we), .pc_sel_exc(pc_sel_exc), .md_busy(md_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: "just took an exception", remaining mul/div busy cycles, statistics.
  bit              m_in_vec;
  int              m_md_left;
  longint unsigned m_stall, m_flush;

  // Expected outputs for the current cycle.
  bit e_pcw, e_ifidw, e_iff, e_idexf, e_exmemf, e_epc, e_sel, e_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    reset = 0; id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; ex_memread = 0;
    branch_taken_id = 0; md_start_ex = 0; id_uses_hilo = 0; id_is_md = 0;
    imem_ready = 1; exc_req_ex = 0;
  endtask

  task automatic predict();
    bit lu, mds;
    {e_pcw, e_ifidw, e_iff, e_idexf, e_exmemf, e_epc, e_sel} = '0;
    e_busy = !reset && (m_md_left > 0);
    lu  = ex_memread && (ex_rt != 0) &&
          (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    mds = (m_md_left > 0) && (id_uses_hilo || id_is_md);
    if (reset) begin
    end else if (m_in_vec) begin
      e_sel = 1; e_pcw = 1; e_iff = 1;
    end else if (exc_req_ex) begin
      e_iff = 1; e_idexf = 1; e_exmemf = 1; e_epc = 1;
    end else if (lu || mds) begin
      e_idexf = 1;
    end else if (branch_taken_id) begin
      e_pcw = 1; e_iff = 1;
    end else if (!imem_ready) begin
      e_iff = 1;
    end else begin
      e_pcw = 1; e_ifidw = 1;
    end
  endtask

  task automatic advance_model();
    if (reset) begin
      m_in_vec = 0; m_md_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pcw && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (e_iff  && m_flush < 64'hFFFF_FFFF) m_flush++;
      if (m_in_vec) begin
        m_in_vec = 0;
        if (m_md_left > 0) m_md_left--;
      end else if (exc_req_ex) begin
        m_in_vec = 1; m_md_left = 0;
      end else if (md_start_ex) begin
        m_md_left = MD;
      end else if (m_md_left > 0) begin
        m_md_left--;
      end
    end
  endtask

  // Called at a negedge with inputs already driven; checks, then crosses one posedge.
  task automatic step();
    #1;
    predict();
    check("pc_write",     {31'd0, pc_write},     {31'd0, e_pcw});
    check("if_id_write",  {31'd0, if_id_write},  {31'd0, e_ifidw});
    check("if_flush",     {31'd0, if_flush},     {31'd0, e_iff});
    check("id_ex_flush",  {31'd0, id_ex_flush},  {31'd0, e_idexf});
    check("ex_mem_flush", {31'd0, ex_mem_flush}, {31'd0, e_exmemf});
    check("epc_we",       {31'd0, epc_we},       {31'd0, e_epc});
    check("pc_sel_exc",   {31'd0, pc_sel_exc},   {31'd0, e_sel});
    check("md_busy",      {31'd0, md_busy},      {31'd0, e_busy});
    if (!reset) begin
      check("stall_cnt", stall_cnt, m_stall[31:0]);
      check("flush_cnt", flush_cnt, m_flush[31:0]);
    end
    @(posedge clk);
    advance_model();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    m_in_vec = 0; m_md_left = 0; m_stall = 0; m_flush = 0;
    idle_inputs();
    @(negedge clk);
    do_reset();
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_flush_cnt", flush_cnt, 32'd0);

    // Load-use on rs, then on the zero register (no stall).
    ex_memread = 1; ex_rt = 5; id_rs = 5; step();
    ex_memread = 0; step();
    check("lu_stall_cnt", stall_cnt, 32'd1);
    ex_memread = 1; ex_rt = 0; id_rs = 0; step();
    ex_memread = 0; step();
    check("lu_r0_no_stall", stall_cnt, 32'd1);

    // Mul/div interlock: busy exactly MD cycles after issue.
    md_start_ex = 1; step();
    md_start_ex = 0; id_uses_hilo = 1;
    for (int i = 0; i < MD; i++) begin
      check("md_busy_window", {31'd0, md_busy}, 32'd1);
      step();
    end
    check("md_released", {31'd0, pc_write}, 32'd1);
    step();
    id_uses_hilo = 0;

    // Branch during imem wait; then hazard beating a branch.
    branch_taken_id = 1; imem_ready = 0; step();
    imem_ready = 1;
    ex_memread = 1; ex_rt = 7; id_rt = 7; id_uses_rt = 1; step();
    idle_inputs();

    // Exception with md busy, exc held into the vector cycle.
    md_start_ex = 1; step();
    md_start_ex = 0; exc_req_ex = 1; step();
    step();
    exc_req_ex = 0; step();

    // Reach stall_cnt=7 inside EXC_VEC, then reset there.
    do_reset();
    ex_memread = 1; ex_rt = 3; id_rs = 3;
    for (int i = 0; i < 6; i++) step();
    idle_inputs(); exc_req_ex = 1; step();
    exc_req_ex = 0;
    check("vec_stall_cnt", stall_cnt, 32'd7);
    check("vec_sel", {31'd0, pc_sel_exc}, 32'd1);
    reset = 1; step();
    reset = 0; step();
    check("post_reset_stall", stall_cnt, 32'd0);

    // Saturation: preload both counters at all-ones.
    force dut.stall_cnt = '1;
    force dut.flush_cnt = '1;
    #1;
    release dut.stall_cnt;
    release dut.flush_cnt;
    m_stall = 64'hFFFF_FFFF; m_flush = 64'hFFFF_FFFF;
    imem_ready = 0; step(); step();
    check("stall_saturated", stall_cnt, 32'hFFFF_FFFF);
    check("flush_saturated", flush_cnt, 32'hFFFF_FFFF);
    do_reset();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      reset           = ($urandom_range(0, 99) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      id_uses_rt      = 1'($urandom);
      ex_memread      = ($urandom_range(0, 3) == 0);
      branch_taken_id = ($urandom_range(0, 4) == 0);
      md_start_ex     = ($urandom_range(0, 9) == 0);
      id_uses_hilo    = ($urandom_range(0, 3) == 0);
      id_is_md        = ($urandom_range(0, 7) == 0);
      imem_ready      = ($urandom_range(0, 4) != 0);
      exc_req_ex      = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
